bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
Multi-cycle, clocked BCD-to-binary converter with a start/done handshake. It runs the reverse double-dabble algorithm: a right shift followed by a per-digit "subtract 3 if ≥8" correction, one iteration per clock. It sits between the keypad/BCD entry path and the ALU operand registers. It replaces wide combinational conversion with a BIN_W-cycle sequence and flags non-decimal digits.

Parameters:
DIGITS, 3, number of BCD digits on bcd_in (input width 4*DIGITS)
BIN_W, 10, binary result width and shift-iteration count; must satisfy 2^BIN_W ≥ 10^DIGITS

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request, sampled only when ready=1
bcd_in  input  4*DIGITS  packed BCD operand, digit 0 in [3:0], captured on the accepting edge
ready  output  1  high in IDLE only
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
err  output  1  last accepted operand contained a digit >9; held until the next accepted start
bin_out  output  BIN_W  last conversion result; held until the next completion

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low.
  - Reset forces state=IDLE, ready=1, busy=0, done=0, err=0, bin_out=0, shift register=0, iteration counter=0.
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - With start=1 at edge k: capture bcd_in.
  - If any nibble >9: set err=1, bin_out=0, go to DONE (no shifting).
  - Otherwise: set err=0, load work register {bcd_in, BIN_W'b0}, set counter=0, go to SHIFT.
  - With start=0: remain in IDLE.
- SHIFT, each edge:
  - Logical right shift of the whole work register by 1.
  - Then, for every 4-bit digit field of the BCD part: if the value is ≥8, subtract 3.
  - All digit corrections use the post-shift values and are applied in the same cycle.
  - Increment the counter.
  - On the edge that completes iteration BIN_W: bin_out ← low BIN_W bits of the work register, go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency:
  - Valid operand: done is high in the cycle following edge k+BIN_W (default: 10 edges after the accepting edge).
  - Invalid operand: done is high in the cycle following edge k.
- Handshake:
  - start is ignored whenever ready=0 (SHIFT or DONE).
  - A request held high through DONE is accepted on the first IDLE edge, so back-to-back throughput is one conversion per BIN_W+2 cycles.
  - bcd_in changes after capture have no effect.
- Output stability:
  - bin_out and err change only on an accepting edge (err, and bin_out=0 on the error path) or on the completion edge.
  - They are otherwise stable and remain valid after done falls.
- Boundary conditions:
  - All-zero operand: result 0, full latency, err=0.
  - All-nines operand (999): result 999 (0x3E7), no overflow at the defaults.
  - Counter must not wrap: width ≥ clog2(BIN_W+1).
- Reset mid-operation: an immediate return to IDLE; a pending done is never issued; bin_out and err clear to 0.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-cycle -> ready=1, busy=0, done=0, err=0, bin_out=0 immediately, without waiting for a clock edge.
2. Conversion of bcd_in=0x999, start pulsed at edge 0 -> busy=1 from edge 0, done high only between edges 10 and 11, bin_out=0x3E7, err=0, ready=1 after edge 11.
3. Operands 0x000, 0x105, 0x080 (each a separate request) -> bin_out=0, 105 (0x069), 80 (0x050) respectively, each done exactly 10 edges after acceptance.
4. Invalid operand bcd_in=0x1A3 -> done high in the cycle after the accepting edge, err=1, bin_out=0. A following 0x042 request -> err=0, bin_out=42.
5. Busy rejection: accept 0x250, drive start=1 with bcd_in=0x777 on edges 3–9 -> bin_out=250, err=0, a single done pulse. Holding start=1 with 0x777 through DONE -> second conversion accepted at the first IDLE edge, bin_out=777.
6. Reset mid-operation: accept 0x512, drop rst_n at edge 5 for one cycle -> no done pulse, bin_out=0. A new request for 0x064 after release -> bin_out=64 with normal 10-edge latency.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift per clock.
// Takes BIN_W cycles per valid operand and flags operands that have any digit greater than 9.
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WORK_W-1:0]    work_q, work_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [BIN_W-1:0]     bin_q, bin_d;

  logic                 bad_digit;
  logic [WORK_W-1:0]    shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
    end
  end

  // Digit corrections act on post-shift values; the binary half is never corrected.
  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end

    shifted = work_q >> 1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (shifted[BIN_W + 4*i +: 4] >= 4'd8) begin
        shifted[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    bin_d   = bin_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad_digit) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            work_d  = {bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          bin_d   = shifted[BIN_W-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign err     = err_q;
  assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq at the default DIGITS=3 and BIN_W=10.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  bin_out;

  int n_checks;
  int n_fail;

  bcd_to_bin_seq #(
    .DIGITS(3),
    .BIN_W (10)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bcd_in (bcd_in),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .bin_out(bin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge with the DUT idle; leaves just after a rising edge, idle again.
  task automatic convert(input string tag, input logic [11:0] bcd, input int exp_lat,
                         input logic [9:0] exp_bin, input logic exp_err);
    int n;
    chk({tag, "_ready_before"}, ready, 1);
    start  = 1'b1;
    bcd_in = bcd;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = ~bcd;
    @(negedge clk);
    chk({tag, "_busy"}, busy, 1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_bin"}, bin_out, exp_bin);
    chk({tag, "_err"}, err, exp_err);
    @(negedge clk);
    chk({tag, "_done_fall"}, done, 0);
    chk({tag, "_ready_after"}, ready, 1);
    chk({tag, "_bin_held"}, bin_out, exp_bin);
    chk({tag, "_err_held"}, err, exp_err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int seen;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    start    = 1'b0;
    bcd_in   = '0;

    // Asynchronous reset before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bin", bin_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    convert("c999", 12'h999, 10, 10'd999, 1'b0);
    convert("c000", 12'h000, 10, 10'd0,   1'b0);
    convert("c105", 12'h105, 10, 10'd105, 1'b0);
    convert("c080", 12'h080, 10, 10'd80,  1'b0);
    convert("c1A3", 12'h1A3, 0,  10'd0,   1'b1);
    convert("c042", 12'h042, 10, 10'd42,  1'b0);

    // Busy rejection, then a request held through DONE
    start  = 1'b1;
    bcd_in = 12'h250;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 12'h777;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(negedge clk);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rej_latency", n, 8);
    chk("rej_bin", bin_out, 10'd250);
    chk("rej_err", err, 0);
    @(negedge clk);
    chk("rej_done_fall", done, 0);
    chk("rej_ready", ready, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    chk("b2b_bin_stable", bin_out, 10'd250);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_latency", n, 10);
    chk("b2b_bin", bin_out, 10'd777);
    chk("b2b_err", err, 0);
    @(posedge clk);
    #1;
    chk("b2b_ready", ready, 1);

    // Reset in the middle of a conversion
    start  = 1'b1;
    bcd_in = 12'h512;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bin", bin_out, 0);
    chk("mid_rst_err", err, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("mid_rst_no_done", seen, 0);
    chk("mid_rst_bin_after", bin_out, 0);
    @(posedge clk);
    #1;
    convert("c064", 12'h064, 10, 10'd64, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
